// File: rtl/set_reset_pulse_encoder_if.sv
// set_reset_pulse_encoder_if: requested level in, set/reset pulses and mirror/busy status out
interface set_reset_pulse_encoder_if;
  logic level;
  logic set;
  logic reset;
  logic mirror;
  logic busy;
  modport master(output level, input set, reset, mirror, busy);
  modport slave(input level, output set, reset, mirror, busy);
endinterface

// File: rtl/set_reset_pulse_encoder.sv
// set_reset_pulse_encoder: turns a level into set/reset pulses for a remote SR flop,
// tracking the remote state in a local mirror with fixed pulse width and holdoff spacing
module set_reset_pulse_encoder #(
  parameter int   PULSE_WIDTH = 1,
  parameter int   HOLDOFF     = 0,
  parameter logic RESET_STATE = 1'b0
) (
  input logic                     i_clock,
  input logic                     i_resetn,
  set_reset_pulse_encoder_if.slave bus
);
  localparam int MX = (PULSE_WIDTH > HOLDOFF) ? PULSE_WIDTH : HOLDOFF;
  localparam int CW = $clog2(MX) + 1;
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_set, r_reset, r_mirror, r_busy;
  logic          w_eval, w_start;
  // a pulse may start from IDLE or on the final cycle of PULSE (no holdoff) / HOLD
  assign w_eval  = (r_state == IDLE) ||
                   (r_state == PULSE && r_cnt == '0 && HOLDOFF == 0) ||
                   (r_state == HOLD && r_cnt == '0);
  assign w_start = w_eval && (bus.level != r_mirror);
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_set    <= 1'b0;
      r_reset  <= 1'b0;
      r_mirror <= RESET_STATE;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_state  <= PULSE;
      r_cnt    <= CW'(PULSE_WIDTH - 1);
      r_set    <= bus.level;
      r_reset  <= ~bus.level;
      r_mirror <= bus.level;
      r_busy   <= 1'b1;
    end else if (r_state != IDLE && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == PULSE && HOLDOFF > 0) begin
      r_state <= HOLD;
      r_cnt   <= CW'(HOLDOFF - 1);
      r_set   <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_state <= IDLE;
      r_set   <= 1'b0;
      r_reset <= 1'b0;
      r_busy  <= 1'b0;
    end
  end
  assign bus.set    = r_set;
  assign bus.reset  = r_reset;
  assign bus.mirror = r_mirror;
  assign bus.busy   = r_busy;
endmodule
